// File: rtl/conv_row_fetch_if.sv
// Read-beat bus from conv_row_fetch to the feature-map buffer consumer.
interface conv_row_fetch_if #(
   parameter int ADDR_W = 16
);
   logic              rd_valid;
   logic              rd_ready;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_pad;
   logic [1:0]        rd_row;
   logic              rd_last;

   modport master (output rd_valid, rd_addr, rd_pad, rd_row, rd_last, input rd_ready);
   modport slave  (input rd_valid, rd_addr, rd_pad, rd_row, rd_last, output rd_ready);
endinterface

// File: rtl/conv_row_fetch.sv
// Walks a column span for up to three input rows, issuing column-major buffer read
// addresses with per-beat zero-padding. CONV_ROW_FETCH_PERF_EN adds perf counters.
module conv_row_fetch #(
   parameter int ADDR_W  = 16,
   parameter int COORD_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [COORD_W-1:0] row_y1,
   input  logic [COORD_W-1:0] row_y2,
   input  logic [COORD_W-1:0] row_y3,
   input  logic [1:0]         rows_used,
   input  logic [COORD_W-1:0] x_start,
   input  logic [COORD_W-1:0] x_len,
   input  logic [COORD_W-1:0] ix,
   input  logic [COORD_W-1:0] iy,
   input  logic [ADDR_W-1:0]  base_addr,
   conv_row_fetch_if.master   rd,
   output logic               busy,
   output logic               stall,
   output logic               done
`ifdef CONV_ROW_FETCH_PERF_EN
   ,
   output logic [31:0]        perf_beats,
   output logic [31:0]        perf_bp
`endif
);
   // two guard bits: x_start + x_len - 1 can exceed the signed COORD_W range
   localparam int XW = COORD_W + 2;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_DONE} state_t;
   state_t state_q, state_d;

   logic [2:0][COORD_W-1:0] ry_q;
   logic [1:0]              nrows_q, load_idx;
   logic [COORD_W-1:0]      xs_q, xl_q, ix_q, iy_q, cols_q;
   logic [ADDR_W-1:0]       base_q;
   logic [2:0][ADDR_W-1:0]  row_off;
   logic [2:0]              row_pad;
   logic signed [XW-1:0]    beat_x;
   logic [1:0]              beat_r;

   logic              v_q, pad_q, last_q;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        row_q;

   logic [COORD_W-1:0]         load_y;
   logic signed [COORD_W:0]    load_ye;
   logic signed [2*COORD_W:0]  prod;
   logic [ADDR_W-1:0]          load_off, off_sel, nxt_addr;
   logic                       load_pad, pad_sel, nxt_pad, nxt_last, last_load, hs;
   logic signed [XW-1:0]       nxt_x;
   logic [1:0]                 nxt_r;
   logic [COORD_W-1:0]         nxt_cols;

   assign hs        = v_q && rd.rd_ready;
   assign last_load = (state_q == S_LOAD) && (load_idx == nrows_q - 2'd1);

   // row offset / row pad for the row being loaded this cycle
   always_comb begin
      load_y   = ry_q[load_idx];
      load_ye  = {load_y[COORD_W-1], load_y};
      prod     = $signed(load_y) * $signed({1'b0, ix_q});
      load_off = prod[ADDR_W-1:0];
      load_pad = load_ye[COORD_W] || (load_ye >= $signed({1'b0, iy_q}));
   end

   // next beat position: first beat out of LOAD, otherwise advance r then x
   always_comb begin
      nxt_x    = beat_x;
      nxt_r    = beat_r + 2'd1;
      nxt_cols = cols_q;
      if (state_q == S_LOAD) begin
         nxt_x    = $signed({{2{xs_q[COORD_W-1]}}, xs_q});
         nxt_r    = 2'd0;
         nxt_cols = xl_q;
      end else if (beat_r == nrows_q - 2'd1) begin
         nxt_x    = beat_x + XW'(1);
         nxt_r    = 2'd0;
         nxt_cols = cols_q - COORD_W'(1);
      end
      // single-row groups issue row 0 the same edge it is loaded
      if ((state_q == S_LOAD) && (nxt_r == load_idx)) begin
         off_sel = load_off;
         pad_sel = load_pad;
      end else begin
         off_sel = row_off[nxt_r];
         pad_sel = row_pad[nxt_r];
      end
      nxt_pad  = pad_sel || nxt_x[XW-1] || (nxt_x >= $signed({2'b00, ix_q}));
      nxt_addr = nxt_pad ? '0 : base_q + off_sel + ADDR_W'(nxt_x);
      nxt_last = (nxt_cols == COORD_W'(1)) && (nxt_r == nrows_q - 2'd1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = (x_len == '0) ? S_DONE : S_LOAD;
         S_LOAD:  if (last_load) state_d = S_ISSUE;
         S_ISSUE: if (hs && last_q) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ry_q     <= '0;
         nrows_q  <= 2'd1;
         load_idx <= '0;
         xs_q     <= '0;
         xl_q     <= '0;
         ix_q     <= '0;
         iy_q     <= '0;
         base_q   <= '0;
         cols_q   <= '0;
         row_off  <= '0;
         row_pad  <= '0;
         beat_x   <= '0;
         beat_r   <= '0;
         v_q      <= 1'b0;
         addr_q   <= '0;
         pad_q    <= 1'b0;
         row_q    <= '0;
         last_q   <= 1'b0;
      end else begin
         if (state_q == S_IDLE && start) begin
            ry_q     <= {row_y3, row_y2, row_y1};
            nrows_q  <= (rows_used == 2'd0) ? 2'd1 : rows_used;
            load_idx <= '0;
            xs_q     <= x_start;
            xl_q     <= x_len;
            ix_q     <= ix;
            iy_q     <= iy;
            base_q   <= base_addr;
         end
         if (state_q == S_LOAD) begin
            row_off[load_idx] <= load_off;
            row_pad[load_idx] <= load_pad;
            load_idx          <= load_idx + 2'd1;
         end
         if (last_load || (hs && !last_q)) begin
            v_q    <= 1'b1;
            beat_x <= nxt_x;
            beat_r <= nxt_r;
            cols_q <= nxt_cols;
            addr_q <= nxt_addr;
            pad_q  <= nxt_pad;
            row_q  <= nxt_r;
            last_q <= nxt_last;
         end else if (hs) begin
            v_q    <= 1'b0;
            addr_q <= '0;
            pad_q  <= 1'b0;
            row_q  <= '0;
            last_q <= 1'b0;
         end
      end
   end

   assign rd.rd_valid = v_q;
   assign rd.rd_addr  = addr_q;
   assign rd.rd_pad   = pad_q;
   assign rd.rd_row   = row_q;
   assign rd.rd_last  = last_q;
   assign busy        = (state_q != S_IDLE);
   assign stall       = busy;
   assign done        = (state_q == S_DONE);

`ifdef CONV_ROW_FETCH_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_beats <= '0;
         perf_bp    <= '0;
      end else begin
         if (hs && perf_beats != '1) perf_beats <= perf_beats + 32'd1;
         if (v_q && !rd.rd_ready && perf_bp != '1) perf_bp <= perf_bp + 32'd1;
      end
   end
`endif
endmodule
